// File: rtl/branch_resolve_pkg.sv
// Shared processor definitions for branch resolution.
//   - 5-bit opcode encodings of every control-transfer instruction
//   - default depth of the post-redirect squash window
//   - resolver FSM state type and the resolved-result struct
//   - resolve(): pure decode of taken/target from conditions and targets
package branch_resolve_pkg;

  localparam int unsigned OPC_W       = 5;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned SQ_CNT_W    = 2;

  // Younger in-flight instructions killed after a taken transfer.
  localparam int unsigned SQUASH_DEPTH_DEF = 2;

  localparam logic [OPC_W-1:0] OPC_J   = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_BNE = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_JAL = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_JR  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_BLT = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_BEX = 5'b10110;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } br_state_e;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } br_res_t;

  // Taken decision and redirect address for one instruction. Non-branch
  // opcodes are never taken; their target is don't-care and forced to 0.
  function automatic br_res_t resolve(
    input logic [OPC_W-1:0] opcode,
    input logic             ne,
    input logic             lt,
    input logic             rstatus_nz,
    input logic [XLEN-1:0]  br_target,
    input logic [XLEN-1:0]  jmp_target,
    input logic [XLEN-1:0]  jr_target
  );
    br_res_t r;
    r.taken  = 1'b0;
    r.target = '0;
    case (opcode)
      OPC_BNE: begin r.taken = ne;         r.target = br_target;  end
      OPC_BLT: begin r.taken = lt;         r.target = br_target;  end
      OPC_J,
      OPC_JAL: begin r.taken = 1'b1;       r.target = jmp_target; end
      OPC_JR:  begin r.taken = 1'b1;       r.target = jr_target;  end
      OPC_BEX: begin r.taken = rstatus_nz; r.target = jmp_target; end
      default: begin r.taken = 1'b0;       r.target = '0;         end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve_cond.sv
// branch_cond: ne/lt flags from an ALU subtract (A - B).
//   sub_result : A - B
//   overflow   : signed overflow of that subtract
//   ne         : A != B
//   lt         : A < B (signed), sign of the true difference
// Purely combinational so the ALU can reuse it.
module branch_cond
  import branch_resolve_pkg::*;
(
  input  logic [XLEN-1:0] sub_result,
  input  logic            overflow,
  output logic            ne,
  output logic            lt
);

  assign ne = |sub_result;
  // Overflow flips the sign bit of the wrapped result.
  assign lt = sub_result[XLEN-1] ^ overflow;

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: resolves control transfers one cycle after acceptance and
// kills the next SQUASH_DEPTH valid instructions after a taken one.
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   stall            : freeze all state; flush is forced low while frozen
//   in_valid, opcode : instruction presented this cycle
//   sub_result, overflow, rstatus_nz : condition sources
//   pc_plus1, br_target, jmp_target, jr_target : candidate next PCs
//   out_valid, taken, next_pc, flush : registered result (latency 1)
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned SQUASH_DEPTH = SQUASH_DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [OPC_W-1:0] opcode,
  input  logic [XLEN-1:0]  sub_result,
  input  logic             overflow,
  input  logic             rstatus_nz,
  input  logic [XLEN-1:0]  pc_plus1,
  input  logic [XLEN-1:0]  br_target,
  input  logic [XLEN-1:0]  jmp_target,
  input  logic [XLEN-1:0]  jr_target,
  output logic             out_valid,
  output logic             taken,
  output logic [XLEN-1:0]  next_pc,
  output logic             flush
);

  localparam logic [SQ_CNT_W-1:0] SQ_INIT = SQUASH_DEPTH[SQ_CNT_W-1:0];

  br_state_e           state_q, state_d;
  logic [SQ_CNT_W-1:0] sq_cnt_q, sq_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                taken_q, taken_d;
  logic                flush_q, flush_d;
  logic [XLEN-1:0]     next_pc_q, next_pc_d;

  logic    ne, lt;
  logic    accept;
  br_res_t res;

  branch_cond u_cond (
    .sub_result (sub_result),
    .overflow   (overflow),
    .ne         (ne),
    .lt         (lt)
  );

  always_comb begin
    res = resolve(opcode, ne, lt, rstatus_nz, br_target, jmp_target, jr_target);
  end

  assign accept = in_valid && !stall && (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    sq_cnt_d    = sq_cnt_q;
    out_valid_d = out_valid_q;
    taken_d     = taken_q;
    next_pc_d   = next_pc_q;
    flush_d     = 1'b0;              // a held flush would redirect twice

    if (!stall) begin
      out_valid_d = accept;
      taken_d     = accept && res.taken;
      flush_d     = accept && res.taken;
      // Not-taken results still report the fall-through PC.
      if (accept) next_pc_d = res.taken ? res.target : pc_plus1;

      case (state_q)
        ST_RUN: begin
          if (accept && res.taken && (SQ_INIT != '0)) begin
            state_d  = ST_SQUASH;
            sq_cnt_d = SQ_INIT;
          end
        end
        ST_SQUASH: begin
          // Only real instructions consume the window; bubbles do not.
          if (in_valid) begin
            if (sq_cnt_q <= 1) begin
              state_d  = ST_RUN;
              sq_cnt_d = '0;
            end else begin
              sq_cnt_d = sq_cnt_q - 1'b1;
            end
          end
        end
        default: begin
          state_d  = ST_RUN;
          sq_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      sq_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      flush_q     <= 1'b0;
      next_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      sq_cnt_q    <= sq_cnt_d;
      out_valid_q <= out_valid_d;
      taken_q     <= taken_d;
      flush_q     <= flush_d;
      next_pc_q   <= next_pc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign taken     = taken_q;
  assign next_pc   = next_pc_q;
  assign flush     = flush_q;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  localparam int SQ = 2;

  localparam logic [4:0] T_J   = 5'b00001;
  localparam logic [4:0] T_BNE = 5'b00010;
  localparam logic [4:0] T_JAL = 5'b00011;
  localparam logic [4:0] T_JR  = 5'b00100;
  localparam logic [4:0] T_BLT = 5'b00110;
  localparam logic [4:0] T_BEX = 5'b10110;
  localparam logic [4:0] T_NOP = 5'b00000;
  localparam logic [4:0] T_ODD = 5'b11111;

  logic        clock = 1'b0;
  logic        reset, stall, in_valid, overflow, rstatus_nz;
  logic [4:0]  opcode;
  logic [31:0] sub_result, pc_plus1, br_target, jmp_target, jr_target;
  logic        out_valid, taken, flush;
  logic [31:0] next_pc;

  int n_cmp = 0;
  int n_bad = 0;

  branch_resolve #(.SQUASH_DEPTH(SQ)) dut (
    .clock(clock), .reset(reset), .stall(stall), .in_valid(in_valid),
    .opcode(opcode), .sub_result(sub_result), .overflow(overflow),
    .rstatus_nz(rstatus_nz), .pc_plus1(pc_plus1), .br_target(br_target),
    .jmp_target(jmp_target), .jr_target(jr_target),
    .out_valid(out_valid), .taken(taken), .next_pc(next_pc), .flush(flush)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // kill_left: how many more real instructions must be thrown away.
  int          kill_left;
  bit          m_ov, m_tk, m_fl;
  logic [31:0] m_pc;

  function automatic bit want_taken(input logic [4:0] op, input logic [31:0] sub,
                                    input logic ovf, input logic rnz);
    case (op)
      T_BNE:             return sub != 32'd0;
      T_BLT:             return sub[31] != ovf;
      T_J, T_JAL, T_JR:  return 1'b1;
      T_BEX:             return rnz;
      default:           return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] want_target(input logic [4:0] op);
    if (op == T_BNE || op == T_BLT) return br_target;
    if (op == T_JR) return jr_target;
    return jmp_target;
  endfunction

  always @(posedge clock) begin
    bit t;
    if (reset) begin
      kill_left = 0; m_ov = 0; m_tk = 0; m_fl = 0; m_pc = 32'd0;
    end else if (stall) begin
      m_fl = 0;
    end else if (in_valid && kill_left == 0) begin
      t    = want_taken(opcode, sub_result, overflow, rstatus_nz);
      m_ov = 1; m_tk = t; m_fl = t;
      m_pc = t ? want_target(opcode) : pc_plus1;
      if (t) kill_left = SQ;
    end else begin
      if (in_valid && kill_left > 0) kill_left--;
      m_ov = 0; m_tk = 0; m_fl = 0;
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    check("taken",     {31'd0, taken},     {31'd0, m_tk});
    check("flush",     {31'd0, flush},     {31'd0, m_fl});
    if (m_tk) check("next_pc", next_pc, m_pc);
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic rst, input logic stl, input logic vld,
                      input logic [4:0] op, input logic [31:0] sub = 32'd0,
                      input logic ovf = 1'b0, input logic rnz = 1'b0,
                      input logic [31:0] brt = 32'h0, input logic [31:0] jmpt = 32'h0,
                      input logic [31:0] jrt = 32'h0);
    reset = rst; stall = stl; in_valid = vld; opcode = op; sub_result = sub;
    overflow = ovf; rstatus_nz = rnz; br_target = brt; jmp_target = jmpt;
    jr_target = jrt; pc_plus1 = pc_plus1 + 32'd1;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Literal expectations on the result of the step just applied.
  task automatic lit(input string name, input logic ov, input logic tk,
                     input logic fl, input logic [31:0] pc, input bit chk_pc);
    check({name, ".ov"}, {31'd0, out_valid}, {31'd0, ov});
    check({name, ".tk"}, {31'd0, taken},     {31'd0, tk});
    check({name, ".fl"}, {31'd0, flush},     {31'd0, fl});
    if (chk_pc) check({name, ".pc"}, next_pc, pc);
  endtask

  initial begin
    pc_plus1 = 32'h100;
    step(1, 0, 0, T_NOP);
    step(1, 1, 1, T_JAL, 0, 0, 0, 0, 32'h999);       // reset beats stall/valid
    lit("reset", 0, 0, 0, 32'h0, 1);

    // not-taken bne, next instruction accepted
    step(0, 0, 1, T_BNE, 32'h0, 0, 0, 32'h40);
    lit("bne_nt", 1, 0, 0, 32'h0, 0);
    step(0, 0, 1, T_NOP);
    lit("after_nt", 1, 0, 0, 32'h0, 0);

    // taken bne: two kills (second is a true-condition bne), third accepted
    step(0, 0, 1, T_BNE, 32'h8000_0000, 0, 0, 32'h40);
    lit("bne_tk", 1, 1, 1, 32'h40, 1);
    step(0, 0, 1, T_NOP);
    lit("kill1", 0, 0, 0, 32'h0, 0);
    step(0, 0, 1, T_BNE, 32'h5, 0, 0, 32'h77);
    lit("kill_br", 0, 0, 0, 32'h0, 0);
    step(0, 0, 1, T_NOP);
    lit("third", 1, 0, 0, 32'h0, 0);

    // blt with overflow
    step(0, 0, 1, T_BLT, 32'h7FFF_FFFF, 1, 0, 32'h80);
    lit("blt_ovf", 1, 1, 1, 32'h80, 1);
    step(0, 0, 1, T_NOP);
    step(0, 0, 1, T_NOP);

    // jal, valid, bubble, valid -> both killed, bubble free
    step(0, 0, 1, T_JAL, 0, 0, 0, 0, 32'h200);
    lit("jal", 1, 1, 1, 32'h200, 1);
    step(0, 0, 1, T_NOP);
    step(0, 0, 0, T_NOP);
    step(0, 0, 1, T_NOP);
    lit("jal_k2", 0, 0, 0, 32'h0, 0);
    step(0, 0, 1, T_NOP);
    lit("jal_acc", 1, 0, 0, 32'h0, 0);

    // jr with a 3-cycle stall inside the squash window
    step(0, 0, 1, T_JR, 0, 0, 0, 0, 0, 32'h123);
    lit("jr", 1, 1, 1, 32'h123, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, T_NOP);
      lit("jr_stall", 1, 1, 0, 32'h123, 1);
    end
    step(0, 0, 1, T_NOP);
    step(0, 0, 1, T_NOP);
    lit("jr_k2", 0, 0, 0, 32'h0, 0);
    step(0, 0, 1, T_NOP);
    lit("jr_acc", 1, 0, 0, 32'h0, 0);

    // bex taken, one kill, then reset with one kill left
    step(0, 0, 1, T_BEX, 0, 0, 1, 0, 32'h300);
    lit("bex", 1, 1, 1, 32'h300, 1);
    step(0, 0, 1, T_NOP);
    step(1, 0, 1, T_NOP);
    lit("mid_rst", 0, 0, 0, 32'h0, 1);
    step(0, 0, 1, T_BNE, 32'h1, 0, 0, 32'h44);
    lit("post_rst", 1, 1, 1, 32'h44, 1);
    step(0, 0, 1, T_NOP);
    step(0, 0, 1, T_NOP);

    // bex not taken, back-to-back resolves, stall holding a not-taken result
    step(0, 0, 1, T_BEX, 0, 0, 0, 0, 32'h300);
    lit("bex_nt", 1, 0, 0, 32'h0, 0);
    step(0, 0, 1, T_BLT, 32'h8000_0000, 1, 0, 32'h90);
    lit("blt_nt", 1, 0, 0, 32'h0, 0);
    step(0, 1, 0, T_NOP);
    lit("stall_hold", 1, 0, 0, 32'h0, 0);
    step(0, 0, 1, T_ODD, 32'hFFFF, 0, 1, 32'h1, 32'h2, 32'h3);
    lit("nonbr", 1, 0, 0, 32'h0, 0);
    step(0, 0, 1, T_J, 0, 0, 0, 0, 32'h3FF_FFFF);
    lit("j", 1, 1, 1, 32'h3FF_FFFF, 1);
    step(0, 0, 0, T_NOP);
    lit("bubble", 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, T_NOP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
